// File: rtl/range_counter_pkg.sv
// Shared types and default parameters for the range_counter block.
package range_counter_pkg;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_e;

    localparam int DEF_WIDTH   = 5;
    localparam int DEF_MIN_VAL = 1;
    localparam int DEF_MAX_VAL = 26;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for a level input. The previous sample resets high so an
// input already asserted when reset releases is not seen as an edge.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic prev_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= d;
        end
    end

    assign rise = d & ~prev_q;

endmodule

// File: rtl/range_counter.sv
// Up/down counter confined to [MIN_VAL, MAX_VAL] with wrap or saturate at the
// boundaries, edge-triggered inc/dec, and a range-checked synchronous load.
module range_counter
    import range_counter_pkg::*;
#(
    parameter int        WIDTH   = DEF_WIDTH,
    parameter int        MIN_VAL = DEF_MIN_VAL,
    parameter int        MAX_VAL = DEF_MAX_VAL,
    parameter cnt_mode_e MODE    = CNT_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             inc,
    input  logic             dec,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] result,
    output logic             at_min,
    output logic             at_max,
    output logic             wrapped,
    output logic             load_err
);

    if (!(MIN_VAL >= 0 && MIN_VAL < MAX_VAL && MAX_VAL <= (1 << WIDTH) - 1)) begin : g_bad_range
        $error("range_counter: need 0 <= MIN_VAL < MAX_VAL <= 2**WIDTH-1");
    end

    // Boundaries carried one bit wider so MAX+1 and MIN-1 are representable.
    localparam logic [WIDTH:0] MIN_W = (WIDTH + 1)'(MIN_VAL);
    localparam logic [WIDTH:0] MAX_W = (WIDTH + 1)'(MAX_VAL);

    logic [WIDTH-1:0] result_q, result_d;
    logic             wrapped_q, wrapped_d;
    logic             load_err_q, load_err_d;
    logic             inc_rise, dec_rise;
    logic [WIDTH:0]   cur_w, up_w, dn_w, load_w;
    logic             load_ok;

    edge_detect u_inc_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (inc),
        .rise (inc_rise)
    );

    edge_detect u_dec_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (dec),
        .rise (dec_rise)
    );

    assign cur_w   = {1'b0, result_q};
    assign up_w    = cur_w + 1'b1;
    assign dn_w    = cur_w - 1'b1;
    assign load_w  = {1'b0, load_value};
    assign load_ok = (load_w >= MIN_W) && (load_w <= MAX_W);

    always_comb begin
        result_d   = result_q;
        wrapped_d  = 1'b0;
        load_err_d = 1'b0;
        if (load) begin
            if (load_ok) begin
                result_d = load_value;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (enable && (inc_rise != dec_rise)) begin
            if (inc_rise) begin
                if (up_w > MAX_W) begin
                    if (MODE == CNT_WRAP) begin
                        result_d  = MIN_W[WIDTH-1:0];
                        wrapped_d = 1'b1;
                    end
                end else begin
                    result_d = up_w[WIDTH-1:0];
                end
            end else begin
                // Test the current value, not dn_w, so MIN_VAL = 0 cannot underflow.
                if (cur_w <= MIN_W) begin
                    if (MODE == CNT_WRAP) begin
                        result_d  = MAX_W[WIDTH-1:0];
                        wrapped_d = 1'b1;
                    end
                end else begin
                    result_d = dn_w[WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            result_q   <= MIN_W[WIDTH-1:0];
            wrapped_q  <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            result_q   <= result_d;
            wrapped_q  <= wrapped_d;
            load_err_q <= load_err_d;
        end
    end

    assign result   = result_q;
    assign at_min   = (cur_w == MIN_W);
    assign at_max   = (cur_w == MAX_W);
    assign wrapped  = wrapped_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_range_counter.sv
// Bench for range_counter: three instances (default wrap, saturate, 4-bit 0..15 wrap)
// share one stimulus stream and are checked every cycle against an arithmetic model.
module tb_range_counter;
    import range_counter_pkg::*;

    logic       clk = 1'b0;
    logic       rst, enable, inc, dec, load;
    logic [4:0] lv;

    logic [4:0] res_a, res_b;
    logic [3:0] res_c;
    logic       amin_a, amax_a, wr_a, le_a;
    logic       amin_b, amax_b, wr_b, le_b;
    logic       amin_c, amax_c, wr_c, le_c;

    always #5 clk = ~clk;

    range_counter #(.WIDTH(5), .MIN_VAL(1), .MAX_VAL(26), .MODE(CNT_WRAP)) dut_a (
        .clk(clk), .rst(rst), .enable(enable), .inc(inc), .dec(dec), .load(load),
        .load_value(lv), .result(res_a), .at_min(amin_a), .at_max(amax_a),
        .wrapped(wr_a), .load_err(le_a)
    );

    range_counter #(.WIDTH(5), .MIN_VAL(1), .MAX_VAL(26), .MODE(CNT_SAT)) dut_b (
        .clk(clk), .rst(rst), .enable(enable), .inc(inc), .dec(dec), .load(load),
        .load_value(lv), .result(res_b), .at_min(amin_b), .at_max(amax_b),
        .wrapped(wr_b), .load_err(le_b)
    );

    range_counter #(.WIDTH(4), .MIN_VAL(0), .MAX_VAL(15), .MODE(CNT_WRAP)) dut_c (
        .clk(clk), .rst(rst), .enable(enable), .inc(inc), .dec(dec), .load(load),
        .load_value(lv[3:0]), .result(res_c), .at_min(amin_c), .at_max(amax_c),
        .wrapped(wr_c), .load_err(le_c)
    );

    // Model: per-instance count and pulses, computed from the boundary rules.
    int p_min[3] = '{1, 1, 0};
    int p_max[3] = '{26, 26, 15};
    int p_sat[3] = '{0, 1, 0};
    int p_w[3]   = '{5, 5, 4};
    int m_res[3];
    int m_wr[3];
    int m_le[3];
    int m_pi, m_pd;
    bit model_ok = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                m_res[i] = p_min[i];
                m_wr[i]  = 0;
                m_le[i]  = 0;
            end
            m_pi = 1;
            m_pd = 1;
            model_ok = 1'b1;
        end else begin
            int ir, dr, lvv, nxt;
            ir = (inc && m_pi == 0) ? 1 : 0;
            dr = (dec && m_pd == 0) ? 1 : 0;
            for (int i = 0; i < 3; i++) begin
                m_wr[i] = 0;
                m_le[i] = 0;
                lvv = int'(lv) % (1 << p_w[i]);
                if (load) begin
                    if (lvv >= p_min[i] && lvv <= p_max[i]) m_res[i] = lvv;
                    else m_le[i] = 1;
                end else if (enable && ir != dr) begin
                    nxt = m_res[i] + ((ir == 1) ? 1 : -1);
                    if (nxt > p_max[i] || nxt < p_min[i]) begin
                        if (p_sat[i] == 1) begin
                            m_res[i] = (ir == 1) ? p_max[i] : p_min[i];
                        end else begin
                            m_res[i] = (ir == 1) ? p_min[i] : p_max[i];
                            m_wr[i]  = 1;
                        end
                    end else begin
                        m_res[i] = nxt;
                    end
                end
            end
            m_pi = inc ? 1 : 0;
            m_pd = dec ? 1 : 0;
        end
    end

    // Compare process: registered outputs are stable at the falling edge.
    always @(negedge clk) begin
        if (model_ok) begin
            int ar[3], amn[3], amx[3], aw[3], al[3];
            ar  = '{int'(res_a), int'(res_b), int'(res_c)};
            amn = '{int'(amin_a), int'(amin_b), int'(amin_c)};
            amx = '{int'(amax_a), int'(amax_b), int'(amax_c)};
            aw  = '{int'(wr_a), int'(wr_b), int'(wr_c)};
            al  = '{int'(le_a), int'(le_b), int'(le_c)};
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("result[%0d]", i), ar[i], m_res[i]);
                chk($sformatf("at_min[%0d]", i), amn[i], (m_res[i] == p_min[i]) ? 1 : 0);
                chk($sformatf("at_max[%0d]", i), amx[i], (m_res[i] == p_max[i]) ? 1 : 0);
                chk($sformatf("wrapped[%0d]", i), aw[i], m_wr[i]);
                chk($sformatf("load_err[%0d]", i), al[i], m_le[i]);
                chk($sformatf("in_range[%0d]", i),
                    (ar[i] >= p_min[i] && ar[i] <= p_max[i]) ? 1 : 0, 1);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic do_load(input int v);
        lv   = 5'(v);
        load = 1'b1;
        cyc(1);
        load = 1'b0;
    endtask

    int wraps;

    initial begin
        rst = 1'b0; enable = 1'b1; inc = 1'b0; dec = 1'b0; load = 1'b0; lv = '0;
        cyc(2);
        rst = 1'b1;
        chk("lit_reset_res_a", int'(res_a), 1);
        chk("lit_reset_min_a", int'(amin_a), 1);
        chk("lit_reset_max_a", int'(amax_a), 0);
        chk("lit_reset_res_c", int'(res_c), 0);

        // Wrap from MAX to MIN on the default instance; saturation holds on dut_b.
        do_load(26);
        chk("lit_load26_a", int'(res_a), 26);
        inc = 1'b1; cyc(1);
        chk("lit_wrap_model_a", m_res[0], 1);
        chk("lit_wrap_res_a", int'(res_a), 1);
        chk("lit_wrap_pulse_a", int'(wr_a), 1);
        chk("lit_wrap_min_a", int'(amin_a), 1);
        chk("lit_sat_max_b", int'(res_b), 26);
        inc = 1'b0; cyc(1);
        chk("lit_wrap_clear_a", int'(wr_a), 0);

        // Three decrements at MIN: saturate on dut_b, wrap down on dut_a.
        do_load(1);
        for (int k = 0; k < 3; k++) begin
            dec = 1'b1; cyc(1);
            chk("lit_sat_min_b", int'(res_b), 1);
            chk("lit_sat_nowrap_b", int'(wr_b), 0);
            dec = 1'b0; cyc(1);
        end
        chk("lit_dec_model_a", m_res[0], 24);
        chk("lit_dec_res_a", int'(res_a), 24);

        // Held-high inc counts once.
        do_load(5);
        inc = 1'b1; cyc(1);
        chk("lit_hold_first_a", int'(res_a), 6);
        cyc(9);
        chk("lit_hold_after_a", int'(res_a), 6);
        inc = 1'b0; cyc(1);

        // Out-of-range load with concurrent edge, then a good load.
        lv = 5'd30; load = 1'b1; inc = 1'b1; cyc(1);
        chk("lit_badload_res_a", int'(res_a), 6);
        chk("lit_badload_err_a", int'(le_a), 1);
        load = 1'b0; inc = 1'b0; cyc(1);
        chk("lit_badload_clear_a", int'(le_a), 0);
        do_load(12);
        chk("lit_goodload_a", int'(res_a), 12);

        // Simultaneous edges cancel; edges with enable low are dropped, not queued.
        do_load(7);
        inc = 1'b1; dec = 1'b1; cyc(1);
        chk("lit_both_a", int'(res_a), 7);
        inc = 1'b0; dec = 1'b0; cyc(1);
        enable = 1'b0; inc = 1'b1; cyc(1);
        chk("lit_disabled_a", int'(res_a), 7);
        enable = 1'b1; cyc(1);
        chk("lit_not_queued_a", int'(res_a), 7);
        inc = 1'b0; cyc(1);

        // 4-bit instance: full lap of 16 increments from 0.
        do_load(0);
        wraps = 0;
        for (int k = 0; k < 16; k++) begin
            inc = 1'b1; cyc(1);
            wraps += int'(wr_c);
            inc = 1'b0; cyc(1);
            wraps += int'(wr_c);
        end
        chk("lit_lap_res_c", int'(res_c), 0);
        chk("lit_lap_wraps_c", wraps, 1);
        chk("lit_lap_min_c", int'(amin_c), 1);
        do_load(15);
        chk("lit_max_flag_c", int'(amax_c), 1);

        // Reset in the middle of activity overrides load and inc.
        do_load(0);
        for (int k = 0; k < 3; k++) begin
            inc = 1'b1; cyc(1);
            inc = 1'b0; cyc(1);
        end
        chk("lit_pre_reset_c", int'(res_c), 3);
        rst = 1'b0; inc = 1'b1; load = 1'b1; lv = 5'd9; cyc(1);
        chk("lit_midreset_c", int'(res_c), 0);
        chk("lit_midreset_a", int'(res_a), 1);
        rst = 1'b1; load = 1'b0; cyc(2);
        chk("lit_held_at_release_c", int'(res_c), 0);
        inc = 1'b0; cyc(1);
        inc = 1'b1; cyc(1);
        chk("lit_after_release_c", int'(res_c), 1);
        inc = 1'b0; cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
